// File: rtl/mvau_pkg.sv
// Shared types and parameter sanity check for the MVAU input buffer controller.
package mvau_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } mvau_ibc_state_t;

  function automatic bit mvau_ibc_params_ok(input int sf, input int nf, input int buf_addr);
    return (sf >= 1) && (nf >= 1) && (buf_addr >= 1) && (buf_addr < 31) &&
           ((1 << buf_addr) >= sf);
  endfunction

endpackage

// File: rtl/mvau_fold_cnt.sv
// Wrap counter 0..LAST with enable and terminal-count flag; tc is combinational.
// Counts on the cycle en is high and wraps to 0 after LAST; holds otherwise.
module mvau_fold_cnt #(
  parameter int W    = 4,
  parameter int LAST = 3
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  assign tc = (cnt == LAST_V);

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mvau_inp_buf_ctrl.sv
// Writes each input vector through the buffer once, then replays it NF-1 times; strobes lag issue by 1 cycle.
// out_rdy=0 stalls everything; optional perf counters with MVAU_INP_BUF_CTRL_PERF_EN.
module mvau_inp_buf_ctrl
  import mvau_pkg::*;
#(
  parameter int SF       = 4,
  parameter int NF       = 3,
  parameter int BUF_ADDR = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                out_rdy,
  output logic                wr_en,
  output logic                rd_en,
  output logic [BUF_ADDR-1:0] addr,
  output logic                out_v,
  output logic                sf_first,
  output logic                sf_last,
  output logic                nf_last
`ifdef MVAU_INP_BUF_CTRL_PERF_EN
  ,
  output logic [31:0]         vec_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int NF_W = $clog2(NF) + 1;
  localparam logic [NF_W-1:0] NF_LAST = NF_W'(NF - 1);

  generate
    if (!mvau_ibc_params_ok(SF, NF, BUF_ADDR)) begin : g_bad_params
      $error("mvau_inp_buf_ctrl: need SF>=1, NF>=1 and 2**BUF_ADDR>=SF");
    end
  endgenerate

  mvau_ibc_state_t     state;
  logic [BUF_ADDR-1:0] sf_cnt;
  logic [NF_W-1:0]     nf_cnt;
  logic                sf_tc;
  logic                nf_tc;
  logic                issue;

  always_comb begin
    in_rdy = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    addr   = sf_cnt;
    if (!areset) begin
      if (state == FILL) begin
        in_rdy = out_rdy;
        wr_en  = in_v & out_rdy;
      end else begin
        rd_en  = out_rdy;
      end
    end
  end

  assign issue = wr_en | rd_en;

  // nf_cnt advances once per finished pass, so the FILL pass moves it 0->1.
  mvau_fold_cnt #(.W(BUF_ADDR), .LAST(SF - 1)) u_sf_cnt (
    .aclk   (aclk),
    .areset (areset),
    .en     (issue),
    .cnt    (sf_cnt),
    .tc     (sf_tc)
  );

  mvau_fold_cnt #(.W(NF_W), .LAST(NF - 1)) u_nf_cnt (
    .aclk   (aclk),
    .areset (areset),
    .en     (issue & sf_tc),
    .cnt    (nf_cnt),
    .tc     (nf_tc)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= FILL;
      out_v    <= 1'b0;
      sf_first <= 1'b0;
      sf_last  <= 1'b0;
      nf_last  <= 1'b0;
    end else begin
      out_v    <= issue;
      sf_first <= issue & (sf_cnt == '0);
      sf_last  <= issue & sf_tc;
      nf_last  <= issue & (nf_cnt == NF_LAST);
      if (issue && sf_tc) begin
        case (state)
          FILL:    if (NF > 1) state <= REPLAY;
          REPLAY:  if (nf_tc)  state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end

`ifdef MVAU_INP_BUF_CTRL_PERF_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      vec_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && sf_tc && nf_tc) vec_cnt <= vec_cnt + 32'd1;
      // An idle FILL (no input offered) is not a stall.
      if (!out_rdy && (state == REPLAY || in_v)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Directed-vector bench for mvau_inp_buf_ctrl (SF=4/NF=3 plus an SF=1/NF=1 instance).
module tb_mvau_inp_buf_ctrl;

  logic       aclk;
  logic       rst, iv, ordy;
  logic       irdy, wr, rd, ov, sff, sfl, nfl;
  logic [3:0] addr;

  logic       s_rst, s_iv, s_ordy;
  logic       s_irdy, s_wr, s_rd, s_ov, s_sff, s_sfl, s_nfl;
  logic [0:0] s_addr;

`ifdef MVAU_INP_BUF_CTRL_PERF_EN
  logic [31:0] vec_cnt, stall_cnt, s_vec_cnt, s_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  mvau_inp_buf_ctrl #(.SF(4), .NF(3), .BUF_ADDR(4)) dut (
    .aclk(aclk), .areset(rst), .in_v(iv), .in_rdy(irdy), .out_rdy(ordy),
    .wr_en(wr), .rd_en(rd), .addr(addr), .out_v(ov),
    .sf_first(sff), .sf_last(sfl), .nf_last(nfl)
`ifdef MVAU_INP_BUF_CTRL_PERF_EN
    , .vec_cnt(vec_cnt), .stall_cnt(stall_cnt)
`endif
  );

  mvau_inp_buf_ctrl #(.SF(1), .NF(1), .BUF_ADDR(1)) dut_s (
    .aclk(aclk), .areset(s_rst), .in_v(s_iv), .in_rdy(s_irdy), .out_rdy(s_ordy),
    .wr_en(s_wr), .rd_en(s_rd), .addr(s_addr), .out_v(s_ov),
    .sf_first(s_sff), .sf_last(s_sfl), .nf_last(s_nfl)
`ifdef MVAU_INP_BUF_CTRL_PERF_EN
    , .vec_cnt(s_vec_cnt), .stall_cnt(s_stall_cnt)
`endif
  );

  typedef struct {
    logic       rst, iv, ordy;
    logic       irdy, wr, rd;
    logic [3:0] addr;
    logic       ov, sff, sfl, nfl;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic i, input logic o,
                     input logic e_irdy, input logic e_wr, input logic e_rd, input int e_addr,
                     input logic e_ov, input logic e_sff, input logic e_sfl, input logic e_nfl);
    vec_t v;
    v.rst = r; v.iv = i; v.ordy = o;
    v.irdy = e_irdy; v.wr = e_wr; v.rd = e_rd; v.addr = 4'(e_addr);
    v.ov = e_ov; v.sff = e_sff; v.sfl = e_sfl; v.nfl = e_nfl;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; ordy = 1'b0;
    s_rst = 1'b1; s_iv = 1'b0; s_ordy = 1'b0;
    repeat (2) @(posedge aclk);

    //  rst iv ordy | irdy wr rd addr | ov sff sfl nfl
    add(1, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0);
    // fill then two replays
    add(0, 1, 1,  1, 1, 0, 0,  0, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0, 1,  1, 1, 0, 0);
    add(0, 1, 1,  1, 1, 0, 2,  1, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0, 3,  1, 0, 0, 0);
    add(0, 0, 1,  0, 0, 1, 0,  1, 0, 1, 0);
    add(0, 0, 1,  0, 0, 1, 1,  1, 1, 0, 0);
    add(0, 0, 1,  0, 0, 1, 2,  1, 0, 0, 0);
    add(0, 0, 1,  0, 0, 1, 3,  1, 0, 0, 0);
    add(0, 0, 1,  0, 0, 1, 0,  1, 0, 1, 0);
    add(0, 0, 1,  0, 0, 1, 1,  1, 1, 0, 1);
    add(0, 0, 1,  0, 0, 1, 2,  1, 0, 0, 1);
    add(0, 0, 1,  0, 0, 1, 3,  1, 0, 0, 1);
    add(0, 0, 1,  1, 0, 0, 0,  1, 0, 1, 1);
    add(0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 0);
    // in_v gap after word 1
    add(0, 1, 1,  1, 1, 0, 0,  0, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0, 1,  1, 1, 0, 0);
    add(0, 0, 1,  1, 0, 0, 2,  1, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 2,  0, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 2,  0, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0, 2,  0, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0, 3,  1, 0, 0, 0);
    // replay with out_rdy toggling
    add(0, 0, 1,  0, 0, 1, 0,  1, 0, 1, 0);
    add(0, 0, 0,  0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 1,  0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 2,  1, 0, 0, 0);
    add(0, 0, 1,  0, 0, 1, 2,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 3,  1, 0, 0, 0);
    add(0, 0, 1,  0, 0, 1, 3,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0,  1, 0, 1, 0);
    add(0, 0, 1,  0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1,  0, 0, 1, 1,  1, 1, 0, 1);
    // reset during pass 2, word 2
    add(1, 0, 1,  0, 0, 0, 2,  1, 0, 0, 1);
    add(0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 1,  1, 1, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0,  0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 1, 1,  1, 1, 0, 1,  0, 0, 0, 0);

    foreach (tv[i]) begin
      @(posedge aclk);
      #1;
      rst = tv[i].rst; iv = tv[i].iv; ordy = tv[i].ordy;
      #3;
      chk("in_rdy",   i, 32'(irdy), 32'(tv[i].irdy));
      chk("wr_en",    i, 32'(wr),   32'(tv[i].wr));
      chk("rd_en",    i, 32'(rd),   32'(tv[i].rd));
      chk("addr",     i, 32'(addr), 32'(tv[i].addr));
      chk("out_v",    i, 32'(ov),   32'(tv[i].ov));
      chk("sf_first", i, 32'(sff),  32'(tv[i].sff));
      chk("sf_last",  i, 32'(sfl),  32'(tv[i].sfl));
      chk("nf_last",  i, 32'(nfl),  32'(tv[i].nfl));
    end

    // SF=1, NF=1: every cycle writes addr 0 and every word is first/last
    @(posedge aclk); #1;
    s_rst = 1'b0; s_iv = 1'b1; s_ordy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3;
      chk("s_wr_en", c, 32'(s_wr),   32'd1);
      chk("s_rd_en", c, 32'(s_rd),   32'd0);
      chk("s_addr",  c, 32'(s_addr), 32'd0);
      if (c > 0) begin
        chk("s_out_v",    c, 32'(s_ov),  32'd1);
        chk("s_sf_first", c, 32'(s_sff), 32'd1);
        chk("s_sf_last",  c, 32'(s_sfl), 32'd1);
        chk("s_nf_last",  c, 32'(s_nfl), 32'd1);
      end else begin
        chk("s_out_v_first", c, 32'(s_ov), 32'd0);
      end
      @(posedge aclk); #1;
    end
    s_iv = 1'b0;

`ifdef MVAU_INP_BUF_CTRL_PERF_EN
    // 5 vectors, 7 counted stalls, plus one idle FILL stall that must not count
    rst = 1'b1; iv = 1'b0; ordy = 1'b1;
    @(posedge aclk); #1;
    rst = 1'b0;
    #3;
    chk("vec_cnt_rst",   0, vec_cnt,   32'd0);
    chk("stall_cnt_rst", 0, stall_cnt, 32'd0);
    @(posedge aclk); #1;
    iv = 1'b1;
    for (int v = 0; v < 5; v++) begin
      ordy = 1'b0;
      @(posedge aclk); #1;
      for (int w = 0; w < 12; w++) begin
        ordy = 1'b1;
        if (v == 0 && w == 6) begin
          ordy = 1'b0;
          repeat (2) @(posedge aclk);
          #1;
          ordy = 1'b1;
        end
        @(posedge aclk); #1;
      end
    end
    iv = 1'b0; ordy = 1'b0;
    @(posedge aclk); #1;
    ordy = 1'b1;
    #3;
    chk("vec_cnt",   0, vec_cnt,   32'd5);
    chk("stall_cnt", 0, stall_cnt, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mvau_inp_buf_ctrl.md
# mvau_inp_buf_ctrl

Control stage directly upstream of the MVAU stream input buffer. It accepts the input activation stream with a valid/ready handshake and drives the buffer's `wr_en`, `rd_en` and `addr`. The first pass of each input vector is written through; the stored vector is then replayed NF-1 times, so every PE row-fold sees the same SF activation words. It also produces the valid and framing strobes that the compute stage uses, aligned with the buffer's registered output.

## Interface
Parameters:
- SF, 4: synapse fold, MatrixW/SIMD; words per input vector.
- NF, 3: neuron fold, MatrixH/PE; number of passes over each vector.
- BUF_ADDR, 4: buffer address width; must satisfy 2**BUF_ADDR >= SF.

Ports:
- aclk  in  1  main clock.
- areset  in  1  reset, synchronous, active-high.
- in_v  in  1  input activation word valid.
- in_rdy  out  1  input word accepted when `in_v & in_rdy`.
- out_rdy  in  1  compute stage can take the word issued this cycle; that word appears next cycle.
- wr_en  out  1  buffer write enable (combinational).
- rd_en  out  1  buffer read enable (combinational).
- addr  out  BUF_ADDR  buffer address (combinational).
- out_v  out  1  buffer `out` holds a valid word this cycle (registered).
- sf_first  out  1  qualifies out_v: the word is index 0 of a pass (compute clears its accumulator).
- sf_last  out  1  qualifies out_v: the word is index SF-1 of a pass (compute emits its result).
- nf_last  out  1  qualifies out_v: the word belongs to pass NF-1.

## Operation
- The FSM has two states, FILL and REPLAY, with a shared `sf_cnt` (BUF_ADDR bits) and an `nf_cnt` ($clog2(NF)+1 bits).
- FILL:
  - `in_rdy = out_rdy`.
  - On the handshake: `wr_en=1`, `addr=sf_cnt`, then sf_cnt increments.
  - Otherwise `wr_en=0` and `addr=sf_cnt`.
- FILL exit, on the handshake at sf_cnt==SF-1:
  - sf_cnt returns to 0.
  - If NF==1, stay in FILL. Otherwise go to REPLAY with nf_cnt=1.
- REPLAY:
  - `in_rdy=0`.
  - If `out_rdy`: `rd_en=1`, `addr=sf_cnt`, then sf_cnt increments.
  - At sf_cnt==SF-1 with out_rdy: sf_cnt returns to 0. If nf_cnt==NF-1, go to FILL with nf_cnt=0; else nf_cnt increments.
- `wr_en` and `rd_en` are never high together.
- When neither is high, `addr` still equals sf_cnt.
- Framing strobes:
  - out_v is `wr_en|rd_en`, registered.
  - sf_first, sf_last and nf_last are the corresponding counter compares, registered.
- SF==1: every issued word asserts both sf_first and sf_last.

## Timing
- Reset values: state=FILL, sf_cnt=0, nf_cnt=0, out_v=0, sf_first=0, sf_last=0, nf_last=0.
- During reset, in_rdy, wr_en and rd_en are forced to 0.
- Latency: an issue in cycle t (wr_en or rd_en) yields buffer data and out_v in cycle t+1.
- Throughput is one word per cycle while out_rdy=1.
- The cycle after the last FILL word issues the first REPLAY read; there are no bubbles.
- out_rdy=0 stalls both states. All counters hold, and out_v=0 in the next cycle.
- in_v=0 in FILL issues nothing, and out_v=0 in the next cycle.
- A reset mid-vector discards the partial vector and the remaining replays. The next accepted word is written to address 0.
- The buffer contents are not cleared; they are overwritten on the next FILL.

## Configuration
- MVAU_INP_BUF_CTRL_PERF_EN defined adds two ports:
  - `vec_cnt` (out, 32): count of completed vectors, incremented as the FSM leaves the last pass of a vector (REPLAY to FILL, or the FILL wrap when NF==1).
  - `stall_cnt` (out, 32): cycles with out_rdy=0. In FILL, only cycles with in_v=1 count.
- Both counters reset to 0 and wrap at 2**32.
- Undefined: neither port nor any counter logic exists, and all other behaviour is identical.

## Structure
- Package `mvau_pkg`:
  - `mvau_ibc_state_t` enum {FILL, REPLAY}.
  - A parameter check function: SF>=1, NF>=1, 2**BUF_ADDR>=SF; an elaboration error if violated.
- One sub-module, `mvau_fold_cnt`:
  - Parameterised wrap counter with enable and terminal-count flag.
  - Instantiated twice, for sf_cnt and nf_cnt.

## Test plan
- Use SF=4 and NF=3 unless noted. Each line gives stimulus -> required response.
- Reset, then 4 words with in_v=1 and out_rdy=1 -> wr_en at addr 0,1,2,3, then rd_en at addr 0..3 twice. out_v is high for 12 consecutive cycles. sf_first on output cycles 1, 5 and 9; sf_last on cycles 4, 8 and 12; nf_last on cycles 9 to 12.
- Toggle out_rdy 1,0 every cycle during REPLAY -> addresses issue only in the out_rdy=1 cycles, in order. out_v follows one cycle later, and no index is skipped or repeated.
- in_v drops for 3 cycles after word 1 -> in_rdy stays high, and addr holds at 2. The next accepted word writes addr 2.
- Assert areset during pass 2, word 2 -> the cycle after reset, out_v=0. The next in_v handshake writes addr 0 in FILL.
- SF=1, NF=1, continuous stream -> every cycle wr_en=1 at addr 0, with sf_first=sf_last=nf_last=1 on every out_v. rd_en is never asserted.
- With MVAU_INP_BUF_CTRL_PERF_EN defined, run 5 vectors with 7 out_rdy=0 cycles -> vec_cnt=5 and stall_cnt=7.
